// File: rtl/csr_pkg.sv
// rtl/csr_pkg.sv - shared state type, size defaults and address helper for the CSR writer
package csr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ROWPTR0,
    ST_SCAN,
    ST_W_VAL,
    ST_W_COL,
    ST_W_RPTR,
    ST_FIN
  } csr_wr_state_t;

  localparam int DEF_N_ROWS = 16;
  localparam int DEF_N_COLS = 16;

  function automatic int cnt_w(input int rows, input int cols);
    return $clog2(rows * cols + 1);
  endfunction

  // Wrap-around is intentional; callers truncate to their address width.
  function automatic logic [63:0] addr_off(input logic [63:0] base, input logic [63:0] off);
    return base + off;
  endfunction

endpackage

// File: rtl/csr_writer_if.sv
// rtl/csr_writer_if.sv - dense element stream in, single memory write port out
interface csr_writer_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) ();
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              WR;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;

  modport master (
    input  in_valid, in_data, wr_ready,
    output in_ready, WR, wr_addr, wr_data
  );

  modport slave (
    output in_valid, in_data, wr_ready,
    input  in_ready, WR, wr_addr, wr_data
  );
endinterface

// File: rtl/csr_wr_port.sv
// rtl/csr_wr_port.sv - one-entry registered write port, stable under backpressure
module csr_wr_port #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              wr,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic              wr_ready,
  output logic              accepted
);
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;

  assign accepted = valid_q && wr_ready;
  assign wr       = valid_q;
  assign wr_addr  = addr_q;
  assign wr_data  = data_q;

  // The FSM only loads when idle or on the accepting cycle, so a pending write is never overwritten.
  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (accepted) valid_d = 1'b0;
    if (load) begin
      valid_d = 1'b1;
      addr_d  = load_addr;
      data_d  = load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end
endmodule

// File: rtl/csr_writer.sv
// rtl/csr_writer.sv - streams a dense row-major matrix out as CSR values, columns and row pointers
module csr_writer
  import csr_pkg::*;
#(
  parameter int N_ROWS = DEF_N_ROWS,
  parameter int N_COLS = DEF_N_COLS,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = cnt_w(N_ROWS, N_COLS)
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] val_base,
  input  logic [ADDR_W-1:0] col_base,
  input  logic [ADDR_W-1:0] row_base,
  csr_writer_if.master      bus,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  nnz
);
  localparam int RW = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
  localparam int CW = (N_COLS > 1) ? $clog2(N_COLS) : 1;
  localparam logic [RW-1:0] LAST_R = RW'(N_ROWS - 1);
  localparam logic [CW-1:0] LAST_C = CW'(N_COLS - 1);

  csr_wr_state_t     state_q, state_d;
  logic [RW-1:0]     r_q, r_d;
  logic [CW-1:0]     c_q, c_d;
  logic [CNT_W-1:0]  nnz_q, nnz_d;
  logic [ADDR_W-1:0] vb_q, vb_d, cb_q, cb_d, rb_q, rb_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic              ld, acc, hs;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;

  function automatic logic [ADDR_W-1:0] at(input logic [ADDR_W-1:0] base, input logic [63:0] off);
    return ADDR_W'(addr_off(64'(base), off));
  endfunction

  assign bus.in_ready = (state_q == ST_SCAN);
  assign hs           = bus.in_valid && (state_q == ST_SCAN);
  assign busy         = busy_q;
  assign done         = done_q;
  assign nnz          = nnz_q;

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    c_d     = c_q;
    nnz_d   = nnz_q;
    vb_d    = vb_q;
    cb_d    = cb_q;
    rb_d    = rb_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ld      = 1'b0;
    ld_addr = '0;
    ld_data = '0;
    case (state_q)
      ST_IDLE: if (start) begin
        vb_d    = val_base;
        cb_d    = col_base;
        rb_d    = row_base;
        r_d     = '0;
        c_d     = '0;
        nnz_d   = '0;
        busy_d  = 1'b1;
        ld      = 1'b1;
        ld_addr = row_base;
        state_d = ST_ROWPTR0;
      end
      ST_ROWPTR0: if (acc) state_d = ST_SCAN;
      ST_SCAN: if (hs) begin
        if (bus.in_data != '0) begin
          ld      = 1'b1;
          ld_addr = at(vb_q, 64'(nnz_q));
          ld_data = bus.in_data;
          state_d = ST_W_VAL;
        end else if (c_q == LAST_C) begin
          ld      = 1'b1;
          ld_addr = at(rb_q, 64'(r_q) + 64'd1);
          ld_data = DATA_W'(nnz_q);
          state_d = ST_W_RPTR;
        end else begin
          c_d = c_q + 1'b1;
        end
      end
      ST_W_VAL: if (acc) begin
        ld      = 1'b1;
        ld_addr = at(cb_q, 64'(nnz_q));
        ld_data = DATA_W'(c_q);
        state_d = ST_W_COL;
      end
      // Row pointer written right after the last column carries the already-incremented count.
      ST_W_COL: if (acc) begin
        nnz_d = nnz_q + 1'b1;
        if (c_q == LAST_C) begin
          ld      = 1'b1;
          ld_addr = at(rb_q, 64'(r_q) + 64'd1);
          ld_data = DATA_W'(nnz_q + 1'b1);
          state_d = ST_W_RPTR;
        end else begin
          c_d     = c_q + 1'b1;
          state_d = ST_SCAN;
        end
      end
      ST_W_RPTR: if (acc) begin
        c_d = '0;
        r_d = r_q + 1'b1;
        if (r_q == LAST_R) begin
          done_d  = 1'b1;
          state_d = ST_FIN;
        end else begin
          state_d = ST_SCAN;
        end
      end
      ST_FIN: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q <= ST_IDLE;
      r_q     <= '0;
      c_q     <= '0;
      nnz_q   <= '0;
      vb_q    <= '0;
      cb_q    <= '0;
      rb_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      c_q     <= c_d;
      nnz_q   <= nnz_d;
      vb_q    <= vb_d;
      cb_q    <= cb_d;
      rb_q    <= rb_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  csr_wr_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_port (
    .clk      (Clk),
    .rst_n    (Rst),
    .load     (ld),
    .load_addr(ld_addr),
    .load_data(ld_data),
    .wr       (bus.WR),
    .wr_addr  (bus.wr_addr),
    .wr_data  (bus.wr_data),
    .wr_ready (bus.wr_ready),
    .accepted (acc)
  );
endmodule

// File: tb/tb_csr_writer.sv
// tb/tb_csr_writer.sv - self-checking bench for csr_writer against a CSR reference model
module tb_csr_writer;
  localparam int NR = 16;
  localparam int NC = 16;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] val_base = '0, col_base = '0, row_base = '0;
  logic        busy, done;
  logic [8:0]  nnz;

  csr_writer_if #(.DATA_W(32), .ADDR_W(32)) bus ();

  csr_writer #(.N_ROWS(NR), .N_COLS(NC), .DATA_W(32), .ADDR_W(32)) dut (
    .Clk(Clk), .Rst(Rst), .start(start),
    .val_base(val_base), .col_base(col_base), .row_base(row_base),
    .bus(bus.master), .busy(busy), .done(done), .nnz(nnz)
  );

  always #5 Clk = ~Clk;

  logic [31:0] mat [NR][NC];
  logic [63:0] got[$], exp_q[$], free_q[$];
  int checks = 0, errors = 0, exp_nnz = 0;
  int RP [17] = '{0, 7, 12, 18, 19, 27, 32, 36, 41, 48, 52, 55, 59, 64, 69, 73, 78};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] nz_rand();
    logic [31:0] v = $urandom;
    return (v == 0) ? 32'd1 : v;
  endfunction

  task automatic gen_random(input int pct);
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++)
        mat[r][c] = ($urandom_range(0, 99) < pct) ? nz_rand() : 32'd0;
  endtask

  // Each row gets exactly RP[r+1]-RP[r] nonzeros scattered over random columns.
  task automatic gen_rowptr();
    for (int r = 0; r < NR; r++) begin
      int need = RP[r+1] - RP[r];
      for (int c = 0; c < NC; c++) begin
        if ($urandom_range(0, NC - c - 1) < need) begin
          mat[r][c] = nz_rand();
          need--;
        end else begin
          mat[r][c] = 32'd0;
        end
      end
    end
  endtask

  function automatic void build_model(input logic [31:0] vb, input logic [31:0] cb, input logic [31:0] rb);
    int k = 0;
    exp_q.delete();
    exp_q.push_back({rb, 32'd0});
    for (int r = 0; r < NR; r++) begin
      for (int c = 0; c < NC; c++) begin
        if (mat[r][c] != 0) begin
          exp_q.push_back({32'(vb + 32'(k)), mat[r][c]});
          exp_q.push_back({32'(cb + 32'(k)), 32'(c)});
          k++;
        end
      end
      exp_q.push_back({32'(rb + 32'(r + 1)), 32'(k)});
    end
    exp_nnz = k;
  endfunction

  task automatic compare_seq(input string tag);
    chk({tag, " count"}, 64'(got.size()), 64'(exp_q.size()));
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      chk($sformatf("%s[%0d]", tag, i), got[i], exp_q[i]);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " in_ready"}, 64'(bus.in_ready), 64'd0);
    chk({tag, " WR"}, 64'(bus.WR), 64'd0);
    chk({tag, " wr_addr"}, 64'(bus.wr_addr), 64'd0);
    chk({tag, " wr_data"}, 64'(bus.wr_data), 64'd0);
    chk({tag, " busy"}, 64'(busy), 64'd0);
    chk({tag, " done"}, 64'(done), 64'd0);
    chk({tag, " nnz"}, 64'(nnz), 64'd0);
  endtask

  // Drives one encode; inputs change and outputs are sampled on the falling edge.
  task automatic run(input int abort_at, input bit bp, input bit dup, output int cycles, output bit fin);
    int idx = 0;
    int cyc = 0;
    bit stall = 0;
    logic [31:0] pa = '0, pd = '0;
    fin = 0;
    got.delete();
    @(negedge Clk);
    start = 1'b1;
    @(posedge Clk);
    cyc = 1;
    while (cyc < 5000) begin
      @(negedge Clk);
      start = dup && (cyc == 6);
      if (dup && cyc == 6) begin
        val_base = 32'h5555_0000;
        col_base = 32'h6666_0000;
        row_base = 32'h7777_0000;
      end
      if (done) begin
        fin = 1;
        break;
      end
      if (stall) begin
        chk("hold WR", 64'(bus.WR), 64'd1);
        chk("hold wr_addr", 64'(bus.wr_addr), 64'(pa));
        chk("hold wr_data", 64'(bus.wr_data), 64'(pd));
      end
      if (abort_at >= 0 && idx == abort_at) begin
        Rst = 1'b0;
        bus.in_valid = 1'b0;
        bus.wr_ready = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
        chk_reset_outputs("abort");
        Rst = 1'b1;
        break;
      end
      bus.in_valid = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.in_data  = (idx < NR * NC) ? mat[idx / NC][idx % NC] : 32'hDEAD_BEEF;
      bus.wr_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.WR && bus.wr_ready) got.push_back({bus.wr_addr, bus.wr_data});
      stall = bus.WR && !bus.wr_ready;
      pa = bus.wr_addr;
      pd = bus.wr_data;
      if (bus.in_valid && bus.in_ready) idx++;
      @(posedge Clk);
      cyc++;
    end
    cycles = cyc + 1;
    start = 1'b0;
    bus.in_valid = 1'b0;
    bus.wr_ready = 1'b0;
  endtask

  initial begin
    int cyc;
    bit fin;
    int n;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.wr_ready = 1'b0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk_reset_outputs("reset");
    Rst = 1'b1;

    gen_rowptr();
    val_base = 32'h1000; col_base = 32'h2000; row_base = 32'h3000;
    build_model(val_base, col_base, row_base);
    run(-1, 0, 0, cyc, fin);
    chk("rp done", 64'(fin), 64'd1);
    chk("rp nnz", 64'(nnz), 64'd78);
    chk("rp cycles", 64'(cyc), 64'(2 + NR * NC + 2 * 78 + NR + 1));
    compare_seq("rp seq");
    n = 0;
    foreach (got[i]) begin
      if (got[i][63:32] >= 32'h3000 && got[i][63:32] <= 32'h3010) begin
        chk($sformatf("rowptr[%0d]", got[i][63:32] - 32'h3000), 64'(got[i][31:0]),
            64'(RP[got[i][63:32] - 32'h3000]));
        n++;
      end
    end
    chk("rowptr writes", 64'(n), 64'd17);
    free_q = got;

    run(-1, 1, 0, cyc, fin);
    chk("bp done", 64'(fin), 64'd1);
    compare_seq("bp model");
    exp_q = free_q;
    compare_seq("bp vs free");

    foreach (mat[r, c]) mat[r][c] = 32'd0;
    build_model(val_base, col_base, row_base);
    run(-1, 0, 0, cyc, fin);
    chk("zero done", 64'(fin), 64'd1);
    chk("zero nnz", 64'(nnz), 64'd0);
    chk("zero cycles", 64'(cyc), 64'd275);
    compare_seq("zero seq");

    foreach (mat[r, c]) mat[r][c] = 32'd1;
    build_model(val_base, col_base, row_base);
    run(-1, 0, 0, cyc, fin);
    chk("dense done", 64'(fin), 64'd1);
    chk("dense nnz", 64'(nnz), 64'd256);
    chk("dense model nnz", 64'(exp_nnz), 64'd256);
    compare_seq("dense seq");

    gen_random(40);
    build_model(val_base, col_base, row_base);
    run(5 * NC + 7, 0, 0, cyc, fin);
    chk("abort no done", 64'(fin), 64'd0);
    run(-1, 0, 0, cyc, fin);
    chk("rerun done", 64'(fin), 64'd1);
    chk("rerun nnz", 64'(nnz), 64'(exp_nnz));
    compare_seq("rerun seq");

    gen_rowptr();
    val_base = 32'hFFFF_FFFE; col_base = 32'h2000; row_base = 32'h3000;
    build_model(val_base, col_base, row_base);
    run(-1, 0, 1, cyc, fin);
    chk("wrap done", 64'(fin), 64'd1);
    chk("wrap nnz", 64'(nnz), 64'd78);
    compare_seq("wrap seq");
    if (got.size() > 5) begin
      chk("wrap val0 addr", 64'(got[1][63:32]), 64'hFFFF_FFFE);
      chk("wrap val2 addr", 64'(got[5][63:32]), 64'h0);
    end

    for (int t = 0; t < 3; t++) begin
      gen_random($urandom_range(5, 80));
      val_base = $urandom; col_base = $urandom; row_base = $urandom;
      build_model(val_base, col_base, row_base);
      run(-1, 1'($urandom_range(0, 1)), 0, cyc, fin);
      chk($sformatf("rand%0d done", t), 64'(fin), 64'd1);
      chk($sformatf("rand%0d nnz", t), 64'(nnz), 64'(exp_nnz));
      compare_seq($sformatf("rand%0d seq", t));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
